post_adder_acc: RTL and testbench
=================================

Name: post_adder_acc

Overview:
- Post-adder / accumulator stage directly downstream of the multiplier-output (M) pipeline register in the DSP slice.
- Selects X and Z operands from M, the concatenated D:A:B word, C, PCIN or its own P feedback.
- Computes Z ± (X + CIN) and drives the P output register and the carry-out register.
- Implements the accumulate/MAC path; PCOUT cascades to the next slice.

Parameters:
- P_WIDTH, 48, width of P/C/PCIN/DAB datapath
- M_WIDTH, 36, width of multiplier product input (signed)
- OPMODEREG, 1, 1 = OPMODE passes through an internal register; 0 = used combinationally
- PREG, 1, 1 = P output registered; 0 = combinational
- CARRYOUTREG, 1, 1 = CARRYOUT registered; 0 = combinational

Ports:
- CLK  in  1  clock, all registers on rising edge
- RST  in  1  reset, asynchronous active-high; clears OPMODE, P and CARRYOUT registers
- CEOPMODE  in  1  clock enable for OPMODE register
- CEP  in  1  clock enable for P and CARRYOUT registers
- OPMODE  in  8  [1:0] X sel, [3:2] Z sel, [5] CIN, [7] subtract; [4],[6] ignored
- M  in  M_WIDTH  product from upstream M pipeline register, two's complement
- DAB  in  P_WIDTH  concatenated D:A:B operand
- C  in  P_WIDTH  C operand (already pipelined upstream)
- PCIN  in  P_WIDTH  cascade input from previous slice
- P  out  P_WIDTH  result
- PCOUT  out  P_WIDTH  cascade output, always equal to P
- CARRYOUT  out  1  carry/no-borrow out of the adder
- CARRYOUTF  out  1  fabric copy, always equal to CARRYOUT

Behaviour:
- Reset:
  - RST=1 asynchronously clears the OPMODE reg, P reg and CARRYOUT reg to 0.
  - Registered outputs read 0 within the same cycle RST asserts.
  - RST has priority over every CE.
- OPMODE path:
  - OPMODEREG=1: internal opm <= OPMODE when CEOPMODE=1, otherwise holds.
  - OPMODEREG=0: opm = OPMODE.
- X mux (opm[1:0]):
  - 0: zero
  - 1: M sign-extended to P_WIDTH
  - 2: P feedback
  - 3: DAB
- Z mux (opm[3:2]):
  - 0: zero
  - 1: PCIN
  - 2: P feedback
  - 3: C
- Feedback with PREG=0: any P-feedback select yields zero, so no combinational loop is possible.
- Arithmetic (all unsigned modulo 2^P_WIDTH, computed at P_WIDTH+1 bits):
  - Let T = X + opm[5].
  - Add (opm[7]=0): {co, s} = Z + T.
  - Subtract (opm[7]=1): s = Z − T; co = 1 iff Z ≥ T (no borrow). T = 2^P_WIDTH (X all-ones with CIN=1) is treated as ≥ any Z, so co = 0.
- P register:
  - PREG=1: P <= s when CEP=1, else holds.
  - PREG=0: P = s.
  - Latency from M/DAB/C/PCIN to P is PREG cycles.
- CARRYOUT register:
  - CARRYOUTREG=1: CARRYOUT <= co on CEP=1.
  - CARRYOUTREG=0: CARRYOUT = co.
- Accumulate: X=M, Z=P with CEP=1 each cycle gives P(n+1) = P(n) + M(n), wrapping at 2^P_WIDTH with CARRYOUT=1 on that cycle.
- CEP=0 freezes P and CARRYOUT; feedback keeps presenting the held P.
- OPMODE change with OPMODEREG=1 affects the adder one cycle after capture; in-flight results keep the previous mode.
- Reset mid-accumulation: P clears immediately and accumulation restarts from 0 on the first post-release edge.
- Cleared opm=0 after reset selects X=0, Z=0, add, CIN=0, so the first P after release is 0 with CARRYOUT=0.

Test Plan:
- Reset/priority: RST=1 with CEP=1, OPMODE=0x0D, M=5, C=7 → P=0, CARRYOUT=0 asynchronously; release → P=0x0C (7+5) one cycle after OPMODE captured.
- Accumulate: OPMODE=0x09 (X=M, Z=P), M=3 for 4 cycles → P = 3, 6, 9, 12; CEP=0 for 2 cycles → P holds 12.
- Subtract/borrow, OPMODE=0x8F (Z=C, X=DAB):
  - C=10, DAB=4 → P=6, CARRYOUT=1.
  - C=4, DAB=10 → P=0xFFFF_FFFF_FFFA, CARRYOUT=0.
- Wrap/carry: OPMODE=0x2F (add, CIN=1), C=0xFFFF_FFFF_FFFF, DAB=0 → P=0, CARRYOUT=1.
- Sign extension/cascade: OPMODE=0x05 (X=M, Z=PCIN), M=−1 (36'hF_FFFF_FFFF), PCIN=1 → P=0, CARRYOUT=1, PCOUT=P.
- Parameter corners: PREG=0, OPMODE=0x0A (both feedback) → P=0 combinational. OPMODEREG=0 → OPMODE change takes effect on the same edge.

Source files
------------

// File: rtl/post_adder_acc.sv
// DSP post-adder / accumulator stage fed by the M pipeline register.
// Computes Z +/- (X + CIN) into the P and CARRYOUT registers.
module post_adder_acc #(
    parameter int P_WIDTH     = 48,
    parameter int M_WIDTH     = 36,
    parameter int OPMODEREG   = 1,
    parameter int PREG        = 1,
    parameter int CARRYOUTREG = 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CEOPMODE,
    input  logic               CEP,
    input  logic [7:0]         OPMODE,
    input  logic [M_WIDTH-1:0] M,
    input  logic [P_WIDTH-1:0] DAB,
    input  logic [P_WIDTH-1:0] C,
    input  logic [P_WIDTH-1:0] PCIN,
    output logic [P_WIDTH-1:0] P,
    output logic [P_WIDTH-1:0] PCOUT,
    output logic               CARRYOUT,
    output logic               CARRYOUTF
);

    logic [7:0]         opm;
    logic [P_WIDTH-1:0] p_fb;
    logic [P_WIDTH-1:0] x_op;
    logic [P_WIDTH-1:0] z_op;
    logic [P_WIDTH:0]   t_ext;
    logic [P_WIDTH:0]   z_ext;
    logic [P_WIDTH:0]   res;
    logic [P_WIDTH-1:0] p_d;
    logic               co_d;
    logic               unused_opm;

    assign unused_opm = ^{opm[6], opm[4]};

    if (OPMODEREG != 0) begin : g_opm_reg
        logic [7:0] opm_q;
        always_ff @(posedge CLK or posedge RST) begin
            if (RST)
                opm_q <= '0;
            else if (CEOPMODE)
                opm_q <= OPMODE;
        end
        assign opm = opm_q;
    end else begin : g_opm_comb
        logic unused_ce;
        assign unused_ce = CEOPMODE;
        assign opm = OPMODE;
    end

    always_comb begin
        x_op = '0;
        unique case (opm[1:0])
            2'd0: x_op = '0;
            2'd1: x_op = {{(P_WIDTH-M_WIDTH){M[M_WIDTH-1]}}, M};
            2'd2: x_op = p_fb;
            2'd3: x_op = DAB;
        endcase
    end

    always_comb begin
        z_op = '0;
        unique case (opm[3:2])
            2'd0: z_op = '0;
            2'd1: z_op = PCIN;
            2'd2: z_op = p_fb;
            2'd3: z_op = C;
        endcase
    end

    // T is one bit wider so all-ones X plus CIN never aliases to zero
    always_comb begin
        t_ext = {1'b0, x_op} + {{P_WIDTH{1'b0}}, opm[5]};
        z_ext = {1'b0, z_op};
        res   = '0;
        co_d  = 1'b0;
        if (opm[7]) begin
            res  = z_ext - t_ext;
            co_d = (z_ext >= t_ext);
        end else begin
            res  = z_ext + t_ext;
            co_d = res[P_WIDTH];
        end
        p_d = res[P_WIDTH-1:0];
    end

    // Without PREG the feedback path is forced to zero to break the loop
    if (PREG != 0) begin : g_p_reg
        logic [P_WIDTH-1:0] p_q;
        always_ff @(posedge CLK or posedge RST) begin
            if (RST)
                p_q <= '0;
            else if (CEP)
                p_q <= p_d;
        end
        assign P    = p_q;
        assign p_fb = p_q;
    end else begin : g_p_comb
        assign P    = p_d;
        assign p_fb = '0;
    end

    if (CARRYOUTREG != 0) begin : g_co_reg
        logic co_q;
        always_ff @(posedge CLK or posedge RST) begin
            if (RST)
                co_q <= 1'b0;
            else if (CEP)
                co_q <= co_d;
        end
        assign CARRYOUT = co_q;
    end else begin : g_co_comb
        logic unused_ce_co;
        assign unused_ce_co = CEP;
        assign CARRYOUT     = co_d;
    end

    assign PCOUT     = P;
    assign CARRYOUTF = CARRYOUT;

endmodule

// File: tb/tb_post_adder_acc.sv
// Directed bench for post_adder_acc: registered, combinational
// and OPMODE-unregistered variants.
module tb_post_adder_acc;

    logic        CLK;
    logic        RST;
    logic        CEOPMODE;
    logic        CEP;
    logic [7:0]  OPMODE;
    logic [35:0] M;
    logic [47:0] DAB;
    logic [47:0] C;
    logic [47:0] PCIN;

    logic [47:0] p_r, pc_r, p_c, pc_c, p_o, pc_o;
    logic        co_r, cof_r, co_c, cof_c, co_o, cof_o;

    int total = 0;
    int bad   = 0;

    post_adder_acc u_dut (
        .CLK(CLK), .RST(RST), .CEOPMODE(CEOPMODE), .CEP(CEP),
        .OPMODE(OPMODE), .M(M), .DAB(DAB), .C(C), .PCIN(PCIN),
        .P(p_r), .PCOUT(pc_r), .CARRYOUT(co_r), .CARRYOUTF(cof_r)
    );

    post_adder_acc #(
        .OPMODEREG(0), .PREG(0), .CARRYOUTREG(0)
    ) u_comb (
        .CLK(CLK), .RST(RST), .CEOPMODE(CEOPMODE), .CEP(CEP),
        .OPMODE(OPMODE), .M(M), .DAB(DAB), .C(C), .PCIN(PCIN),
        .P(p_c), .PCOUT(pc_c), .CARRYOUT(co_c), .CARRYOUTF(cof_c)
    );

    post_adder_acc #(
        .OPMODEREG(0), .PREG(1), .CARRYOUTREG(1)
    ) u_oreg0 (
        .CLK(CLK), .RST(RST), .CEOPMODE(CEOPMODE), .CEP(CEP),
        .OPMODE(OPMODE), .M(M), .DAB(DAB), .C(C), .PCIN(PCIN),
        .P(p_o), .PCOUT(pc_o), .CARRYOUT(co_o), .CARRYOUTF(cof_o)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic [7:0]  opm;
        logic [35:0] m;
        logic [47:0] dab;
        logic [47:0] c;
        logic [47:0] pcin;
        logic [47:0] p;
        logic        co;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [47:0] act,
                       input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_r(input string name, input logic [47:0] ep,
                         input logic eco);
        chk({name, ".P"}, p_r, ep);
        chk({name, ".PCOUT"}, pc_r, ep);
        chk({name, ".CO"}, {47'd0, co_r}, {47'd0, eco});
        chk({name, ".COF"}, {47'd0, cof_r}, {47'd0, eco});
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Two edges: one to capture OPMODE, one to compute with it
    task automatic run2(input logic [7:0] op, input logic [35:0] m,
                        input logic [47:0] dab, input logic [47:0] c,
                        input logic [47:0] pcin);
        OPMODE = op;
        M      = m;
        DAB    = dab;
        C      = c;
        PCIN   = pcin;
        step();
        step();
    endtask

    initial begin
        vecs[0]  = '{8'h0A, 36'd9, 48'd4, 48'd7, 48'd3, 48'd0, 1'b0};
        vecs[1]  = '{8'h8F, 36'd0, 48'd4, 48'd10, 48'd0, 48'd6, 1'b1};
        vecs[2]  = '{8'h8F, 36'd0, 48'd10, 48'd4, 48'd0,
                     48'hFFFF_FFFF_FFFA, 1'b0};
        vecs[3]  = '{8'h2F, 36'd0, 48'd0, 48'hFFFF_FFFF_FFFF, 48'd0,
                     48'd0, 1'b1};
        vecs[4]  = '{8'h05, 36'hF_FFFF_FFFF, 48'd0, 48'd0, 48'd1,
                     48'd0, 1'b1};
        vecs[5]  = '{8'h0D, 36'd5, 48'd0, 48'd7, 48'd0, 48'd12, 1'b0};
        vecs[6]  = '{8'hAF, 36'd0, 48'd4, 48'd10, 48'd0, 48'd5, 1'b1};
        vecs[7]  = '{8'hAF, 36'd0, 48'hFFFF_FFFF_FFFF,
                     48'hFFFF_FFFF_FFFF, 48'd0,
                     48'hFFFF_FFFF_FFFF, 1'b0};
        vecs[8]  = '{8'h80, 36'd0, 48'd0, 48'd0, 48'd0, 48'd0, 1'b1};
        vecs[9]  = '{8'h0E, 36'd0, 48'd0, 48'h1234, 48'd0,
                     48'h1234, 1'b0};
        vecs[10] = '{8'h5D, 36'd5, 48'd0, 48'd7, 48'd0, 48'd12, 1'b0};

        RST      = 1'b1;
        CEP      = 1'b1;
        CEOPMODE = 1'b1;
        OPMODE   = 8'h0D;
        M        = 36'd5;
        C        = 48'd7;
        DAB      = 48'd0;
        PCIN     = 48'd0;
        #1;
        chk_r("rst_async", 48'd0, 1'b0);
        step();
        step();
        chk_r("rst_prio", 48'd0, 1'b0);
        RST = 1'b0;
        step();
        chk_r("rel_first", 48'd0, 1'b0);
        step();
        chk_r("rel_c_plus_m", 48'h0C, 1'b0);

        OPMODE = 8'h00;
        CEP    = 1'b0;
        step();
        chk_r("cep0_hold", 48'h0C, 1'b0);
        CEP = 1'b1;
        step();
        chk_r("clear_p", 48'd0, 1'b0);
        OPMODE = 8'h09;
        CEP    = 1'b0;
        step();
        M   = 36'd3;
        CEP = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk_r($sformatf("acc%0d", i), 48'(3 * i), 1'b0);
        end
        CEP = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk_r($sformatf("acc_hold%0d", i), 48'd12, 1'b0);
        end

        CEP = 1'b1;
        step();
        chk_r("acc5", 48'd15, 1'b0);
        #2;
        RST = 1'b1;
        #1;
        chk_r("rst_mid", 48'd0, 1'b0);
        step();
        RST = 1'b0;
        step();
        chk_r("restart0", 48'd0, 1'b0);
        step();
        chk_r("restart1", 48'd3, 1'b0);

        run2(8'h0C, 36'd3, 48'd0, 48'hFFFF_FFFF_FFFE, 48'd0);
        chk_r("load_c", 48'hFFFF_FFFF_FFFE, 1'b0);
        OPMODE = 8'h09;
        step();
        chk_r("inflight_mode", 48'hFFFF_FFFF_FFFE, 1'b0);
        step();
        chk_r("acc_wrap", 48'd1, 1'b1);

        run2(8'h8F, 36'd0, 48'd4, 48'd10, 48'd0);
        chk_r("sub_pos", 48'd6, 1'b1);
        run2(8'h8F, 36'd0, 48'd10, 48'd4, 48'd0);
        chk_r("sub_neg", 48'hFFFF_FFFF_FFFA, 1'b0);
        run2(8'h2F, 36'd0, 48'd0, 48'hFFFF_FFFF_FFFF, 48'd0);
        chk_r("add_wrap", 48'd0, 1'b1);
        run2(8'h05, 36'hF_FFFF_FFFF, 48'd0, 48'd0, 48'd1);
        chk_r("sext_pcin", 48'd0, 1'b1);

        OPMODE = 8'h0D;
        M      = 36'd5;
        C      = 48'd7;
        step();
        chk("oreg0_same_edge", p_o, 48'd12);
        OPMODE = 8'h8F;
        DAB    = 48'd4;
        C      = 48'd10;
        step();
        chk("oreg0_sub", p_o, 48'd6);
        chk("oreg0_co", {47'd0, co_o}, 48'd1);
        OPMODE = 8'h09;
        M      = 36'd3;
        step();
        chk("oreg0_fb", p_o, 48'd9);
        chk("oreg0_pcout", pc_o, 48'd9);
        chk("oreg0_cof", {47'd0, cof_o}, 48'd0);

        CEP = 1'b0;
        for (int i = 0; i < 11; i++) begin
            OPMODE = vecs[i].opm;
            M      = vecs[i].m;
            DAB    = vecs[i].dab;
            C      = vecs[i].c;
            PCIN   = vecs[i].pcin;
            #1;
            chk($sformatf("comb%0d.P", i), p_c, vecs[i].p);
            chk($sformatf("comb%0d.PCOUT", i), pc_c, vecs[i].p);
            chk($sformatf("comb%0d.CO", i), {47'd0, co_c},
                {47'd0, vecs[i].co});
            chk($sformatf("comb%0d.COF", i), {47'd0, cof_c},
                {47'd0, vecs[i].co});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
